mux5_rr_arbiter: RTL

Round-robin arbiter and sequencer that shares one 5:1 multiplexer among five requesters. It grants one requester at a time, drives the mux select, and routes the winner's data bit to a single output. A hold limit bounds each grant so no requester starves. It sits directly in front of the 5:1 mux datapath.

---
 rtl/mux5_arb_pkg.sv | 14 +
 rtl/rr_pick5.sv | 28 ++
 rtl/mux5_rr_arbiter.sv | 125 ++++++++++++
 3 files changed

// File: rtl/mux5_arb_pkg.sv
// Shared constants, state encoding and pointer-wrap helper for the
// five-way round-robin mux arbiter.
package mux5_arb_pkg;

  localparam int N_REQ = 5;
  localparam logic [2:0] SEL_IDLE = 3'd5;

  typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;

  function automatic logic [2:0] inc_mod5(input logic [2:0] x);
    return (x >= 3'd4) ? 3'd0 : x + 3'd1;
  endfunction

endpackage

// File: rtl/rr_pick5.sv
// Combinational first-set search over five requests, starting at `start`
// and wrapping 4 -> 0.
module rr_pick5
  import mux5_arb_pkg::*;
(
  input  logic [4:0] req,
  input  logic [2:0] start,
  output logic [2:0] idx,
  output logic       found
);

  int pos;

  // Walk from farthest to nearest so the position closest to `start` wins.
  always_comb begin
    idx   = 3'd0;
    found = 1'b0;
    pos   = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      pos = (int'(start) + k) % N_REQ;
      if (req[pos]) begin
        idx   = 3'(pos);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux5_rr_arbiter.sv
// Round-robin arbiter sharing a 5:1 mux: one owner at a time, tenure bounded
// by MAX_HOLD cycles, winner's data bit routed combinationally to dout.
module mux5_rr_arbiter
  import mux5_arb_pkg::*;
#(
  parameter int MAX_HOLD = 4  // legal range 1..15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] req,
  input  logic [4:0] din,
  output logic [4:0] gnt,
  output logic [2:0] sel,
  output logic       dout,
  output logic       busy,
  output arb_state_t dbg_state,
  output logic [2:0] dbg_ptr,
  output logic [3:0] dbg_hold_cnt
);

  // Handshake: req[i] is a level request sampled every rising edge; gnt[i]
  // is the registered answer one cycle later and stays high only while the
  // tenure continues. There is no ready side; dropping req releases the mux.

  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

  arb_state_t state;
  logic [2:0] ptr;
  logic [3:0] hold_cnt;

  logic       owner_req;
  logic       tenure_end;
  logic [2:0] search_start;
  logic [2:0] win_idx;
  logic       win_found;

  always_comb begin
    owner_req = 1'b0;
    case (sel)
      3'd0:    owner_req = req[0];
      3'd1:    owner_req = req[1];
      3'd2:    owner_req = req[2];
      3'd3:    owner_req = req[3];
      3'd4:    owner_req = req[4];
      default: owner_req = 1'b0;
    endcase
  end

  assign tenure_end = (state == ARB_GRANT) && (!owner_req || hold_cnt == HOLD_LAST);

  // Searching from owner+1 over the full request vector makes the old owner
  // the last candidate, so it is re-granted only when nobody else asks.
  assign search_start = (state == ARB_GRANT) ? inc_mod5(sel) : ptr;

  rr_pick5 u_pick (
    .req   (req),
    .start (search_start),
    .idx   (win_idx),
    .found (win_found)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ARB_IDLE;
      gnt      <= 5'd0;
      sel      <= SEL_IDLE;
      busy     <= 1'b0;
      ptr      <= 3'd0;
      hold_cnt <= 4'd0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (win_found) begin
            state    <= ARB_GRANT;
            gnt      <= 5'd1 << win_idx;
            sel      <= win_idx;
            busy     <= 1'b1;
            ptr      <= inc_mod5(win_idx);
            hold_cnt <= 4'd0;
          end
        end
        ARB_GRANT: begin
          if (!tenure_end) begin
            hold_cnt <= hold_cnt + 4'd1;
          end else if (win_found) begin
            gnt      <= 5'd1 << win_idx;
            sel      <= win_idx;
            ptr      <= inc_mod5(win_idx);
            hold_cnt <= 4'd0;
          end else begin
            state    <= ARB_IDLE;
            gnt      <= 5'd0;
            sel      <= SEL_IDLE;
            busy     <= 1'b0;
            hold_cnt <= 4'd0;
          end
        end
        default: begin
          state    <= ARB_IDLE;
          gnt      <= 5'd0;
          sel      <= SEL_IDLE;
          busy     <= 1'b0;
          hold_cnt <= 4'd0;
        end
      endcase
    end
  end

  always_comb begin
    dout = 1'b0;
    case (sel)
      3'd0:    dout = din[0];
      3'd1:    dout = din[1];
      3'd2:    dout = din[2];
      3'd3:    dout = din[3];
      3'd4:    dout = din[4];
      default: dout = 1'b0;
    endcase
  end

  assign dbg_state    = state;
  assign dbg_ptr      = ptr;
  assign dbg_hold_cnt = hold_cnt;

endmodule
